iiq: RTL and testbench
======================

IIQ -- requirements
Module: iiq

Interface
REQ-001 Parameter N_ENTRIES, default 8, is the number of issue queue entries; it is a power of two, at least 2.
REQ-002 Parameter ROB_ID_W, default `ROB_ID_WIDTH, is the width of ROB tags.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_aL  input  1  reset, asynchronous, active-low.
REQ-005 dispatch_ready  output  1  queue can accept one entry this cycle.
REQ-006 dispatch_valid  input  1  dispatch offers an entry.
REQ-007 dispatch_data  input  iiq_entry_t  entry fields: src1/src2 valid, rob_id, ready, data; dst_valid; instr_rob_id; alu_ctrl; pc; branch prediction.
REQ-008 alu_issue_ready  input  1  ALU accepts an instruction this cycle.
REQ-009 alu_issue_valid  output  1  an issue-ready entry is presented.
REQ-010 alu_issue_data  output  iiq_entry_t  selected entry, with captured operands.
REQ-011 wakeup_valid  output  1  the issued instruction writes a destination.
REQ-012 wakeup_rob_id  output  ROB_ID_W  tag of the issued instruction.
REQ-013 alu_broadcast_valid / alu_broadcast_rob_id / alu_broadcast_reg_data  input  1 / ROB_ID_W / 32  ALU result broadcast.
REQ-014 ld_broadcast_valid / ld_broadcast_rob_id / ld_broadcast_reg_data  input  1 / ROB_ID_W / 32  load result broadcast.
REQ-015 flush  input  1  misprediction flush (alu_br_mispred OR ld_mispred).

Function
REQ-016 dispatch_ready SHALL be 1 exactly when the occupied-entry count is below N_ENTRIES; issue in the same cycle SHALL NOT raise dispatch_ready when the queue is full.
REQ-017 Dispatch handshake (dispatch_valid && dispatch_ready && !flush) SHALL write the entry into a free slot at the next edge and tag it as youngest.
REQ-018 An entry SHALL be issue-ready when it is valid and each source is either not valid or ready.
REQ-019 alu_issue_valid SHALL be combinational: 1 when any entry is issue-ready and flush=0; alu_issue_data SHALL be the oldest issue-ready entry (dispatch order).
REQ-020 Issue handshake (alu_issue_valid && alu_issue_ready) SHALL free the selected slot at the next edge; at most one issue and one dispatch per cycle.
REQ-021 wakeup_valid SHALL equal issue handshake AND the selected entry's dst_valid; wakeup_rob_id SHALL equal its instr_rob_id. Otherwise wakeup_rob_id is don't-care.
REQ-022 Internal wakeup SHALL set srcN_ready at the next edge in every valid entry whose srcN_valid=1 and srcN_rob_id matches wakeup_rob_id; data is not captured (the ALU forwards it).
REQ-023 An ALU or load broadcast matching a valid source tag SHALL set srcN_ready and capture srcN_data at the next edge.
REQ-024 When both broadcasts match the same source in the same cycle, the ALU data SHALL win.
REQ-025 flush=1 SHALL invalidate all entries at the next edge, drop any same-cycle dispatch, and force alu_issue_valid=0 and wakeup_valid=0 that cycle.
REQ-026 Age order SHALL remain correct across any sequence of slot reuse, including more than N_ENTRIES dispatches with no gap.

Reset
REQ-027 While rst_aL=0, all entries SHALL be invalid and the count SHALL be 0: dispatch_ready=1, alu_issue_valid=0, wakeup_valid=0.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Configuration
REQ-029 With IIQ_DISPATCH_BYPASS_EN defined, wakeups and broadcasts in the dispatch-handshake cycle that match a dispatching source SHALL be applied to the written entry (ready, plus data for broadcasts).
REQ-030 Without IIQ_DISPATCH_BYPASS_EN, the entry SHALL be written exactly as received; the dispatch stage is then responsible for that bypass.

Verification
REQ-031 Reset, then dispatch with both sources ready, rob_id 3, dst_valid=1, alu_issue_ready=1 -> alu_issue_valid=1 the next cycle; wakeup_valid=1, wakeup_rob_id=3.
REQ-032 Dispatch A (src1 tag 5, not ready), then B (both sources ready); ALU broadcast tag 5 with data 0xDEADBEEF -> B issues first; A issues after the broadcast edge with src1_data=0xDEADBEEF.
REQ-033 Fill 8 entries with alu_issue_ready=0 -> dispatch_ready=0 on the 8th edge; one issue -> dispatch_ready=1 on the following cycle.
REQ-034 Dispatch A (dst tag 2) and C (src1 tag 2); issue A -> C's src1_ready=1 next edge; C issues the following cycle.
REQ-035 With 4 entries held, assert flush together with dispatch_valid -> alu_issue_valid=0 that cycle; count=0 next cycle; the dispatched entry is absent.
REQ-036 ALU and load broadcast the same tag 7, with data 0x11 and 0x22 respectively -> the waiting source captures 0x11.

Source files
------------

// File: rtl/iiq_if.sv
// Integer issue queue: shared entry type and the handshake/bus interface.
// The ROB tag width comes from `ROB_ID_WIDTH; it falls back to 6 when the
// surrounding build does not define it.

`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 6
`endif

package iiq_pkg;

   localparam int IIQ_ROB_ID_W = `ROB_ID_WIDTH;

   // One queued ALU instruction with its two source operands.
   typedef struct packed {
      logic                    src1_valid;
      logic [IIQ_ROB_ID_W-1:0] src1_rob_id;
      logic                    src1_ready;
      logic [31:0]             src1_data;
      logic                    src2_valid;
      logic [IIQ_ROB_ID_W-1:0] src2_rob_id;
      logic                    src2_ready;
      logic [31:0]             src2_data;
      logic                    dst_valid;
      logic [IIQ_ROB_ID_W-1:0] instr_rob_id;
      logic [3:0]              alu_ctrl;
      logic [31:0]             pc;
      logic                    br_pred_taken;
   } iiq_entry_t;

endpackage

// Dispatch, issue, wakeup, broadcast and flush signals of the queue.
// master = surrounding pipeline, slave = the queue itself.
interface iiq_if #(
   parameter int ROB_ID_W = iiq_pkg::IIQ_ROB_ID_W
);
   import iiq_pkg::*;

   // dispatch side
   logic                dispatch_ready;
   logic                dispatch_valid;
   iiq_entry_t          dispatch_data;

   // issue side
   logic                alu_issue_ready;
   logic                alu_issue_valid;
   iiq_entry_t          alu_issue_data;

   // internal wakeup produced by the queue on issue
   logic                wakeup_valid;
   logic [ROB_ID_W-1:0] wakeup_rob_id;

   // result broadcasts
   logic                alu_broadcast_valid;
   logic [ROB_ID_W-1:0] alu_broadcast_rob_id;
   logic [31:0]         alu_broadcast_reg_data;
   logic                ld_broadcast_valid;
   logic [ROB_ID_W-1:0] ld_broadcast_rob_id;
   logic [31:0]         ld_broadcast_reg_data;

   // misprediction flush
   logic                flush;

   modport master (
      input  dispatch_ready,
      output dispatch_valid,
      output dispatch_data,
      output alu_issue_ready,
      input  alu_issue_valid,
      input  alu_issue_data,
      input  wakeup_valid,
      input  wakeup_rob_id,
      output alu_broadcast_valid,
      output alu_broadcast_rob_id,
      output alu_broadcast_reg_data,
      output ld_broadcast_valid,
      output ld_broadcast_rob_id,
      output ld_broadcast_reg_data,
      output flush
   );

   modport slave (
      output dispatch_ready,
      input  dispatch_valid,
      input  dispatch_data,
      input  alu_issue_ready,
      output alu_issue_valid,
      output alu_issue_data,
      output wakeup_valid,
      output wakeup_rob_id,
      input  alu_broadcast_valid,
      input  alu_broadcast_rob_id,
      input  alu_broadcast_reg_data,
      input  ld_broadcast_valid,
      input  ld_broadcast_rob_id,
      input  ld_broadcast_reg_data,
      input  flush
   );

endinterface

// File: rtl/iiq.sv
// Integer issue queue. Holds up to N_ENTRIES dispatched ALU instructions,
// tracks operand readiness from internal wakeups and ALU/load broadcasts,
// and issues the oldest ready entry each cycle.
// Age order is kept in an N x N matrix (older_q[i][j] = slot i older than
// slot j), so any pattern of slot reuse keeps exact dispatch order.
// Optional feature: define IIQ_DISPATCH_BYPASS_EN to apply same-cycle
// wakeups/broadcasts to the entry being written by dispatch.

`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 6
`endif

module iiq #(
   parameter int N_ENTRIES = 8,
   parameter int ROB_ID_W  = `ROB_ID_WIDTH
) (
   input  logic  clk,
   input  logic  rst_aL,
   iiq_if.slave  bus
);
   import iiq_pkg::*;

   localparam int IDX_W = (N_ENTRIES > 1) ? $clog2(N_ENTRIES) : 1;
   typedef logic [IDX_W-1:0] idx_t;

   // Entry payload, valid bits and age matrix
   iiq_entry_t                            ent_q [N_ENTRIES];
   iiq_entry_t                            ent_d [N_ENTRIES];
   logic [N_ENTRIES-1:0]                  valid_q, valid_d;
   logic [N_ENTRIES-1:0][N_ENTRIES-1:0]   older_q, older_d;

   // Selection and handshake signals
   logic [N_ENTRIES-1:0] rdy_vec;
   logic [N_ENTRIES-1:0] sel_vec;
   idx_t                 sel_idx;
   idx_t                 free_idx;
   logic                 any_rdy;
   logic                 any_free;
   logic                 dispatch_hs;
   logic                 issue_hs;
   iiq_entry_t           sel_entry;

   // Applies one cycle of tag matches to an entry. The internal wakeup only
   // marks the source ready (the ALU forwards the value); broadcasts also
   // capture data. The ALU broadcast is applied last so its data wins when
   // both broadcasts hit the same source.
   function automatic iiq_entry_t apply_wakeups(
      input iiq_entry_t          e,
      input logic                wk_v,
      input logic [ROB_ID_W-1:0] wk_id,
      input logic                alu_v,
      input logic [ROB_ID_W-1:0] alu_id,
      input logic [31:0]         alu_data,
      input logic                ld_v,
      input logic [ROB_ID_W-1:0] ld_id,
      input logic [31:0]         ld_data
   );
      iiq_entry_t r;
      r = e;
      if (r.src1_valid) begin
         if (wk_v && (r.src1_rob_id == wk_id)) begin
            r.src1_ready = 1'b1;
         end
         if (ld_v && (r.src1_rob_id == ld_id)) begin
            r.src1_ready = 1'b1;
            r.src1_data  = ld_data;
         end
         if (alu_v && (r.src1_rob_id == alu_id)) begin
            r.src1_ready = 1'b1;
            r.src1_data  = alu_data;
         end
      end
      if (r.src2_valid) begin
         if (wk_v && (r.src2_rob_id == wk_id)) begin
            r.src2_ready = 1'b1;
         end
         if (ld_v && (r.src2_rob_id == ld_id)) begin
            r.src2_ready = 1'b1;
            r.src2_data  = ld_data;
         end
         if (alu_v && (r.src2_rob_id == alu_id)) begin
            r.src2_ready = 1'b1;
            r.src2_data  = alu_data;
         end
      end
      return r;
   endfunction

   // Issue readiness per slot: valid and every used source is ready
   always_comb begin
      for (int i = 0; i < N_ENTRIES; i++) begin
         rdy_vec[i] = valid_q[i]
                    && (!ent_q[i].src1_valid || ent_q[i].src1_ready)
                    && (!ent_q[i].src2_valid || ent_q[i].src2_ready);
      end
   end

   // Oldest-ready pick: a ready slot loses if any other ready slot is older
   always_comb begin
      sel_vec = rdy_vec;
      for (int i = 0; i < N_ENTRIES; i++) begin
         for (int j = 0; j < N_ENTRIES; j++) begin
            if (rdy_vec[j] && older_q[j][i]) begin
               sel_vec[i] = 1'b0;
            end
         end
      end
   end

   // Encode the one-hot pick and find the lowest free slot
   always_comb begin
      sel_idx  = '0;
      free_idx = '0;
      for (int i = 0; i < N_ENTRIES; i++) begin
         if (sel_vec[i]) begin
            sel_idx = idx_t'(i);
         end
      end
      for (int i = N_ENTRIES - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_idx = idx_t'(i);
         end
      end
   end

   assign any_rdy   = |rdy_vec;
   assign any_free  = ~&valid_q;
   assign sel_entry = ent_q[sel_idx];

   // Handshakes; flush suppresses both issue and dispatch for the cycle
   assign dispatch_hs = bus.dispatch_valid && any_free && !bus.flush;
   assign issue_hs    = bus.alu_issue_valid && bus.alu_issue_ready;

   assign bus.dispatch_ready  = any_free;
   assign bus.alu_issue_valid = any_rdy && !bus.flush;
   assign bus.alu_issue_data  = sel_entry;
   assign bus.wakeup_valid    = issue_hs && sel_entry.dst_valid;
   assign bus.wakeup_rob_id   = sel_entry.instr_rob_id;

   // Next state: operand updates, issue free, dispatch write, flush
   // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      valid_d = valid_q;
      older_d = older_q;
      for (int i = 0; i < N_ENTRIES; i++) begin
         ent_d[i] = ent_q[i];
         if (valid_q[i]) begin
            ent_d[i] = apply_wakeups(ent_q[i],
                                     bus.wakeup_valid, bus.wakeup_rob_id,
                                     bus.alu_broadcast_valid, bus.alu_broadcast_rob_id,
                                     bus.alu_broadcast_reg_data,
                                     bus.ld_broadcast_valid, bus.ld_broadcast_rob_id,
                                     bus.ld_broadcast_reg_data);
         end
      end

      if (issue_hs) begin
         valid_d[sel_idx] = 1'b0;
      end

      if (dispatch_hs) begin
         valid_d[free_idx] = 1'b1;
`ifdef IIQ_DISPATCH_BYPASS_EN
         ent_d[free_idx] = apply_wakeups(bus.dispatch_data,
                                         bus.wakeup_valid, bus.wakeup_rob_id,
                                         bus.alu_broadcast_valid, bus.alu_broadcast_rob_id,
                                         bus.alu_broadcast_reg_data,
                                         bus.ld_broadcast_valid, bus.ld_broadcast_rob_id,
                                         bus.ld_broadcast_reg_data);
`else
         ent_d[free_idx] = bus.dispatch_data;
`endif
         // Every other slot becomes older than the new one; the row clear
         // comes last so the new slot is older than nobody (diagonal too).
         for (int i = 0; i < N_ENTRIES; i++) begin
            older_d[i][free_idx] = 1'b1;
         end
         older_d[free_idx] = '0;
      end

      if (bus.flush) begin
         valid_d = '0;
      end
   end

   // Control state: valid bits and age matrix, cleared asynchronously
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_aL) begin
      if (!rst_aL) begin
         valid_q <= '0;
         older_q <= '0;
      end else begin
         valid_q <= valid_d;
         older_q <= older_d;
      end
   end

   // Entry payload storage
   // NOTE: payload has no reset; it is only observed through valid_q, which is reset.
   always_ff @(posedge clk) begin
      ent_q <= ent_d;
   end

   // The pick is one-hot whenever anything is ready
   a_sel_onehot : assert property (@(posedge clk) disable iff (!rst_aL)
      $onehot0(sel_vec));
   a_sel_exists : assert property (@(posedge clk) disable iff (!rst_aL)
      any_rdy |-> (|sel_vec));

endmodule

// File: tb/tb_iiq.sv
// Directed bench for the integer issue queue: reset, issue/wakeup, broadcast
// capture and priority, full/back-pressure, age order on slot reuse, flush,
// and asynchronous mid-run reset.

module tb_iiq;
   import iiq_pkg::*;

   localparam int W = IIQ_ROB_ID_W;

   logic clk = 1'b0;
   logic rst_aL;

   always #5 clk = ~clk;

   iiq_if #(.ROB_ID_W(W)) bus ();

   iiq #(.N_ENTRIES(8), .ROB_ID_W(W)) dut (
      .clk    (clk),
      .rst_aL (rst_aL),
      .bus    (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Builds an entry; source data and pc are derived from the tag so
   // captured values are distinguishable from dispatched ones.
   function automatic iiq_entry_t mk(input bit s1v, input int s1id, input bit s1r,
                                     input bit s2v, input int s2id, input bit s2r,
                                     input bit dv, input int rob);
      iiq_entry_t e;
      e              = '0;
      e.src1_valid   = s1v;
      e.src1_rob_id  = W'(s1id);
      e.src1_ready   = s1r;
      e.src1_data    = 32'hA000_0000 | 32'(rob);
      e.src2_valid   = s2v;
      e.src2_rob_id  = W'(s2id);
      e.src2_ready   = s2r;
      e.src2_data    = 32'hB000_0000 | 32'(rob);
      e.dst_valid    = dv;
      e.instr_rob_id = W'(rob);
      e.alu_ctrl     = 4'h3;
      e.pc           = 32'h400 + 32'(rob * 4);
      return e;
   endfunction

   function automatic iiq_entry_t rdy_entry(input int rob, input bit dv);
      return mk(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, dv, rob);
   endfunction

   task automatic idle();
      bus.dispatch_valid         = 1'b0;
      bus.dispatch_data          = '0;
      bus.alu_issue_ready        = 1'b0;
      bus.alu_broadcast_valid    = 1'b0;
      bus.alu_broadcast_rob_id   = '0;
      bus.alu_broadcast_reg_data = '0;
      bus.ld_broadcast_valid     = 1'b0;
      bus.ld_broadcast_rob_id    = '0;
      bus.ld_broadcast_reg_data  = '0;
      bus.flush                  = 1'b0;
   endtask

   // Run-time bound: the directed sequence needs well under 2000 ns
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "tb_iiq timeout");
   end

   // Directed sequence: inputs change just after the falling edge and
   // outputs are sampled 1 ns later, well clear of the rising edge.
   initial begin
      rst_aL = 1'b0;
      idle();
      #2;
      check("rst_dispatch_ready", 64'(bus.dispatch_ready), 64'd1);
      check("rst_issue_valid",    64'(bus.alu_issue_valid), 64'd0);
      check("rst_wakeup_valid",   64'(bus.wakeup_valid), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_aL = 1'b1;

      // Single ready instruction issues the cycle after dispatch
      @(negedge clk);
      bus.dispatch_valid  = 1'b1;
      bus.dispatch_data   = rdy_entry(3, 1'b1);
      bus.alu_issue_ready = 1'b1;
      #1;
      check("t1_empty_issue_valid", 64'(bus.alu_issue_valid), 64'd0);
      @(negedge clk);
      bus.dispatch_valid = 1'b0;
      #1;
      check("t1_issue_valid",   64'(bus.alu_issue_valid), 64'd1);
      check("t1_issue_rob",     64'(bus.alu_issue_data.instr_rob_id), 64'd3);
      check("t1_wakeup_valid",  64'(bus.wakeup_valid), 64'd1);
      check("t1_wakeup_rob",    64'(bus.wakeup_rob_id), 64'd3);
      @(negedge clk);
      bus.alu_issue_ready = 1'b0;
      #1;
      check("t1_freed", 64'(bus.alu_issue_valid), 64'd0);

      // Younger ready entry bypasses an older waiting one; ALU broadcast
      @(negedge clk);
      bus.dispatch_valid = 1'b1;
      bus.dispatch_data  = mk(1'b1, 5, 1'b0, 1'b0, 0, 1'b0, 1'b1, 10);
      @(negedge clk);
      bus.dispatch_data  = rdy_entry(11, 1'b1);
      #1;
      check("t2_a_waiting", 64'(bus.alu_issue_valid), 64'd0);
      @(negedge clk);
      bus.dispatch_valid  = 1'b0;
      bus.alu_issue_ready = 1'b1;
      #1;
      check("t2_b_first", 64'(bus.alu_issue_data.instr_rob_id), 64'd11);
      @(negedge clk);
      bus.alu_broadcast_valid    = 1'b1;
      bus.alu_broadcast_rob_id   = W'(5);
      bus.alu_broadcast_reg_data = 32'hDEAD_BEEF;
      #1;
      check("t2_a_not_yet", 64'(bus.alu_issue_valid), 64'd0);
      @(negedge clk);
      bus.alu_broadcast_valid = 1'b0;
      #1;
      check("t2_a_valid",      64'(bus.alu_issue_valid), 64'd1);
      check("t2_a_rob",        64'(bus.alu_issue_data.instr_rob_id), 64'd10);
      check("t2_a_src1_ready", 64'(bus.alu_issue_data.src1_ready), 64'd1);
      check("t2_a_src1_data",  64'(bus.alu_issue_data.src1_data), 64'hDEAD_BEEF);
      @(negedge clk);
      bus.alu_issue_ready = 1'b0;
      #1;
      check("t2_empty", 64'(bus.alu_issue_valid), 64'd0);

      // Fill to capacity, back-pressure, then age order across slot reuse
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus.dispatch_valid = 1'b1;
         bus.dispatch_data  = rdy_entry(20 + i, 1'b0);
         #1;
         check($sformatf("t3_ready_before_%0d", i), 64'(bus.dispatch_ready), 64'd1);
      end
      @(negedge clk);
      bus.dispatch_data   = rdy_entry(99, 1'b0);
      bus.alu_issue_ready = 1'b1;
      #1;
      check("t3_full_ready",  64'(bus.dispatch_ready), 64'd0);
      check("t3_full_issue",  64'(bus.alu_issue_valid), 64'd1);
      check("t3_oldest_rob",  64'(bus.alu_issue_data.instr_rob_id), 64'd20);
      @(negedge clk);
      bus.alu_issue_ready = 1'b0;
      bus.dispatch_data   = rdy_entry(30, 1'b0);
      #1;
      check("t3_ready_after_issue", 64'(bus.dispatch_ready), 64'd1);
      @(negedge clk);
      bus.dispatch_valid  = 1'b0;
      bus.alu_issue_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         check($sformatf("t3_drain_%0d", k), 64'(bus.alu_issue_data.instr_rob_id),
               (k < 7) ? 64'(21 + k) : 64'd30);
         @(negedge clk);
      end
      #1;
      check("t3_drained", 64'(bus.alu_issue_valid), 64'd0);
      bus.alu_issue_ready = 1'b0;

      // Internal wakeup from an issued producer readies its consumer
      @(negedge clk);
      bus.dispatch_valid = 1'b1;
      bus.dispatch_data  = rdy_entry(2, 1'b1);
      @(negedge clk);
      bus.dispatch_data  = mk(1'b1, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 40);
      @(negedge clk);
      bus.dispatch_valid  = 1'b0;
      bus.alu_issue_ready = 1'b1;
      #1;
      check("t4_a_rob",        64'(bus.alu_issue_data.instr_rob_id), 64'd2);
      check("t4_wakeup_valid", 64'(bus.wakeup_valid), 64'd1);
      check("t4_wakeup_rob",   64'(bus.wakeup_rob_id), 64'd2);
      @(negedge clk);
      #1;
      check("t4_c_valid",      64'(bus.alu_issue_valid), 64'd1);
      check("t4_c_rob",        64'(bus.alu_issue_data.instr_rob_id), 64'd40);
      check("t4_c_src1_ready", 64'(bus.alu_issue_data.src1_ready), 64'd1);
      check("t4_c_no_wakeup",  64'(bus.wakeup_valid), 64'd0);
      @(negedge clk);
      bus.alu_issue_ready = 1'b0;
      #1;
      check("t4_empty", 64'(bus.alu_issue_valid), 64'd0);

      // Flush with four entries held and a same-cycle dispatch
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         bus.dispatch_valid = 1'b1;
         bus.dispatch_data  = rdy_entry(50 + i, 1'b1);
      end
      @(negedge clk);
      bus.dispatch_data   = rdy_entry(54, 1'b1);
      bus.flush           = 1'b1;
      bus.alu_issue_ready = 1'b1;
      #1;
      check("t5_flush_issue_valid",  64'(bus.alu_issue_valid), 64'd0);
      check("t5_flush_wakeup_valid", 64'(bus.wakeup_valid), 64'd0);
      @(negedge clk);
      bus.flush          = 1'b0;
      bus.dispatch_valid = 1'b0;
      #1;
      check("t5_after_issue_valid",   64'(bus.alu_issue_valid), 64'd0);
      check("t5_after_dispatch_rdy",  64'(bus.dispatch_ready), 64'd1);
      bus.alu_issue_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus.dispatch_valid = 1'b1;
         bus.dispatch_data  = rdy_entry(56 + i, 1'b0);
         if (i == 7) begin
            #1;
            check("t5_count_zero_after_flush", 64'(bus.dispatch_ready), 64'd1);
         end
      end
      @(negedge clk);
      bus.dispatch_valid = 1'b0;
      #1;
      check("t5_refilled_full", 64'(bus.dispatch_ready), 64'd0);
      check("t5_oldest_rob",    64'(bus.alu_issue_data.instr_rob_id), 64'd56);
      @(negedge clk);
      bus.flush = 1'b1;
      @(negedge clk);
      bus.flush = 1'b0;
      #1;
      check("t5_cleared", 64'(bus.dispatch_ready), 64'd1);

      // ALU data wins over load data for the same tag; load-only capture
      @(negedge clk);
      bus.dispatch_valid = 1'b1;
      bus.dispatch_data  = mk(1'b0, 0, 1'b0, 1'b1, 7, 1'b0, 1'b0, 45);
      @(negedge clk);
      bus.dispatch_data  = mk(1'b1, 9, 1'b0, 1'b0, 0, 1'b0, 1'b0, 46);
      @(negedge clk);
      bus.dispatch_valid         = 1'b0;
      bus.alu_broadcast_valid    = 1'b1;
      bus.alu_broadcast_rob_id   = W'(7);
      bus.alu_broadcast_reg_data = 32'h11;
      bus.ld_broadcast_valid     = 1'b1;
      bus.ld_broadcast_rob_id    = W'(7);
      bus.ld_broadcast_reg_data  = 32'h22;
      #1;
      check("t6_none_ready", 64'(bus.alu_issue_valid), 64'd0);
      @(negedge clk);
      bus.alu_broadcast_valid   = 1'b0;
      bus.ld_broadcast_rob_id   = W'(9);
      bus.ld_broadcast_reg_data = 32'h33;
      #1;
      check("t6_d_rob",       64'(bus.alu_issue_data.instr_rob_id), 64'd45);
      check("t6_d_src2_data", 64'(bus.alu_issue_data.src2_data), 64'h11);
      @(negedge clk);
      bus.ld_broadcast_valid = 1'b0;
      bus.alu_issue_ready    = 1'b1;
      #1;
      check("t6_d_issue_valid", 64'(bus.alu_issue_valid), 64'd1);
      @(negedge clk);
      #1;
      check("t6_e_rob",        64'(bus.alu_issue_data.instr_rob_id), 64'd46);
      check("t6_e_src1_ready", 64'(bus.alu_issue_data.src1_ready), 64'd1);
      check("t6_e_src1_data",  64'(bus.alu_issue_data.src1_data), 64'h33);
      @(negedge clk);
      bus.alu_issue_ready = 1'b0;

      // Asynchronous reset mid-run clears entries before any clock edge
      bus.dispatch_valid = 1'b1;
      bus.dispatch_data  = rdy_entry(61, 1'b1);
      @(negedge clk);
      bus.dispatch_valid = 1'b0;
      #1;
      check("t7_held", 64'(bus.alu_issue_valid), 64'd1);
      #1;
      rst_aL = 1'b0;
      #1;
      check("t7_async_issue_valid",  64'(bus.alu_issue_valid), 64'd0);
      check("t7_async_dispatch_rdy", 64'(bus.dispatch_ready), 64'd1);
      @(negedge clk);
      rst_aL = 1'b1;
      #1;
      check("t7_stays_empty", 64'(bus.alu_issue_valid), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
